// File: rtl/sd_read_supervisor.sv
// sd_read_supervisor: session supervisor wrapped around an sd_file_reader.
// It pulses the reader's reset, waits for the file to be found, forwards the
// byte stream with one cycle of registered latency, and uses an idle timeout
// to detect end of file. A search timeout triggers a bounded number of restarts.
module sd_read_supervisor #(
  parameter int RESTART_CYCLES = 1000,
  parameter int FIND_TIMEOUT   = 100000000,
  parameter int IDLE_TIMEOUT   = 50000000,
  parameter int MAX_RETRY      = 3,
  parameter int AUTO_START     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        reader_rst_n,
  input  logic        file_found,
  input  logic        in_req,
  input  logic [7:0]  in_byte,
  output logic        out_req,
  output logic [7:0]  out_byte,
  output logic [31:0] byte_count,
  output logic [3:0]  retry_cnt,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // Terminal counts: each timer runs from 0 and acts on its last cycle.
  localparam logic [31:0] HOLD_LAST   = 32'(RESTART_CYCLES - 1);
  localparam logic [31:0] SEARCH_LAST = 32'(FIND_TIMEOUT - 1);
  localparam logic [31:0] IDLE_LAST   = 32'(IDLE_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);
  localparam logic        AUTO_INIT   = (AUTO_START != 0) ? 1'b1 : 1'b0;
  localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

  state_t      state_r,  state_nx_s;
  logic [31:0] timer_r,  timer_nx_s;
  logic [3:0]  retry_r,  retry_nx_s;
  logic [31:0] count_r,  count_nx_s;
  logic        out_req_r;
  logic [7:0]  out_byte_r;
  logic        rrst_n_r, rrst_n_nx_s;
  logic        busy_r,   busy_nx_s;
  logic        done_r,   done_nx_s;
  logic        fail_r,   fail_nx_s;
  logic        auto_pend_r;
  logic        go_s;
  logic        fwd_s;

  assign reader_rst_n = rrst_n_r;
  assign out_req      = out_req_r;
  assign out_byte     = out_byte_r;
  assign byte_count   = count_r;
  assign retry_cnt    = retry_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign fail         = fail_r;

  // A session starts on a start pulse, or once right after reset when auto-start is set.
  assign go_s = start | auto_pend_r;

  // Next-state, timer, retry and byte-count logic.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    retry_nx_s = retry_r;
    count_nx_s = count_r;
    fwd_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (go_s) begin
          state_nx_s = ST_HOLD;
          timer_nx_s = 32'd0;
          retry_nx_s = 4'd0;
          count_nx_s = 32'd0;
        end else begin
          timer_nx_s = 32'd0;
        end
      end
      ST_HOLD: begin
        if (timer_r == HOLD_LAST) begin
          state_nx_s = ST_SEARCH;
          timer_nx_s = 32'd0;
        end else begin
          timer_nx_s = timer_r + 32'd1;
        end
      end
      ST_SEARCH: begin
        // A byte arriving while still searching is forwarded on the transition.
        fwd_s = in_req;
        if (file_found || in_req) begin
          state_nx_s = ST_STREAM;
          timer_nx_s = 32'd0;
        end else if (timer_r == SEARCH_LAST) begin
          timer_nx_s = 32'd0;
          if (retry_r < RETRY_MAX) begin
            retry_nx_s = retry_r + 4'd1;
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_FAIL;
          end
        end else begin
          timer_nx_s = timer_r + 32'd1;
        end
      end
      ST_STREAM: begin
        // Here the timer counts consecutive cycles without a byte.
        fwd_s = in_req;
        if (in_req) begin
          timer_nx_s = 32'd0;
        end else if (timer_r == IDLE_LAST) begin
          state_nx_s = ST_DONE;
          timer_nx_s = 32'd0;
        end else begin
          timer_nx_s = timer_r + 32'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        timer_nx_s = 32'd0;
      end
    endcase
    if (fwd_s && (count_r != COUNT_MAX)) begin
      count_nx_s = count_r + 32'd1;
    end else begin
      count_nx_s = count_nx_s;
    end
  end

  // Status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rrst_n_nx_s = 1'b0;
    busy_nx_s   = 1'b0;
    done_nx_s   = 1'b0;
    fail_nx_s   = 1'b0;
    case (state_nx_s)
      ST_IDLE:   rrst_n_nx_s = 1'b0;
      ST_HOLD:   busy_nx_s   = 1'b1;
      ST_SEARCH: begin
        rrst_n_nx_s = 1'b1;
        busy_nx_s   = 1'b1;
      end
      ST_STREAM: begin
        rrst_n_nx_s = 1'b1;
        busy_nx_s   = 1'b1;
      end
      ST_DONE: begin
        rrst_n_nx_s = 1'b1;
        done_nx_s   = 1'b1;
      end
      ST_FAIL:   fail_nx_s   = 1'b1;
      default:   rrst_n_nx_s = 1'b0;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= 32'd0;
      retry_r     <= 4'd0;
      count_r     <= 32'd0;
      out_req_r   <= 1'b0;
      out_byte_r  <= 8'd0;
      rrst_n_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      auto_pend_r <= AUTO_INIT;
    end else begin
      state_r     <= state_nx_s;
      timer_r     <= timer_nx_s;
      retry_r     <= retry_nx_s;
      count_r     <= count_nx_s;
      out_req_r   <= fwd_s;
      out_byte_r  <= fwd_s ? in_byte : out_byte_r;
      rrst_n_r    <= rrst_n_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      fail_r      <= fail_nx_s;
      auto_pend_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_read_supervisor.sv
// Directed testbench for sd_read_supervisor with short timeouts.
module tb_sd_read_supervisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        reader_rst_n;
  logic        file_found;
  logic        in_req;
  logic [7:0]  in_byte;
  logic        out_req;
  logic [7:0]  out_byte;
  logic [31:0] byte_count;
  logic [3:0]  retry_cnt;
  logic        busy;
  logic        done;
  logic        fail;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  sd_read_supervisor #(
    .RESTART_CYCLES(4),
    .FIND_TIMEOUT(100),
    .IDLE_TIMEOUT(20),
    .MAX_RETRY(2),
    .AUTO_START(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .reader_rst_n(reader_rst_n),
    .file_found(file_found),
    .in_req(in_req),
    .in_byte(in_byte),
    .out_req(out_req),
    .out_byte(out_byte),
    .byte_count(byte_count),
    .retry_cnt(retry_cnt),
    .busy(busy),
    .done(done),
    .fail(fail)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stay in the reader-reset phase until it ends (bounded).
  task automatic count_hold(output int len);
    len = 0;
    while (reader_rst_n == 1'b0 && busy == 1'b1 && len < 50) begin
      len++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; file_found = 1'b0; in_req = 1'b0; in_byte = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_reader_rst_n", 32'(reader_rst_n), 32'd0);
    check_eq("rst_out_req", 32'(out_req), 32'd0);
    check_eq("rst_byte_count", byte_count, 32'd0);
    check_eq("rst_flags", {29'd0, busy, done, fail}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("no_autostart_busy", 32'(busy), 32'd0);

    // Session 1: found at search cycle 10, two bytes, then silence.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("s1_busy", 32'(busy), 32'd1);
    count_hold(n);
    check_eq("s1_hold_len", 32'(n), 32'd4);
    repeat (9) tick();
    file_found = 1'b1; tick(); file_found = 1'b0;
    check_eq("s1_stream_busy", 32'(busy), 32'd1);
    check_eq("s1_no_early_req", 32'(out_req), 32'd0);
    in_req = 1'b1; in_byte = 8'h48; tick();
    check_eq("s1_b0_req", 32'(out_req), 32'd1);
    check_eq("s1_b0_byte", 32'(out_byte), 32'h48);
    check_eq("s1_b0_cnt", byte_count, 32'd1);
    in_byte = 8'h69; start = 1'b1; tick(); start = 1'b0; in_req = 1'b0;
    check_eq("s1_b1_req", 32'(out_req), 32'd1);
    check_eq("s1_b1_byte", 32'(out_byte), 32'h69);
    check_eq("s1_b1_cnt", byte_count, 32'd2);
    check_eq("s1_start_ignored", {30'd0, busy, reader_rst_n}, 32'd3);
    tick(); n = 1;
    check_eq("s1_single_strobe", 32'(out_req), 32'd0);
    while (!done && n < 100) begin
      tick(); n++;
    end
    check_eq("s1_done_latency", 32'(n), 32'd20);
    check_eq("s1_done_flags", {29'd0, busy, done, fail}, 32'd2);
    check_eq("s1_final_cnt", byte_count, 32'd2);
    check_eq("s1_done_reader_rst_n", 32'(reader_rst_n), 32'd1);

    // Session 2: restart from DONE, byte in HOLD dropped, empty file.
    in_req = 1'b1; in_byte = 8'hAA; start = 1'b1; tick(); start = 1'b0;
    check_eq("s2_cnt_cleared", byte_count, 32'd0);
    check_eq("s2_flags", {29'd0, busy, done, fail}, 32'd4);
    check_eq("s2_reader_rst_n", 32'(reader_rst_n), 32'd0);
    tick();
    check_eq("s2_hold_drop", 32'(out_req), 32'd0);
    check_eq("s2_hold_cnt", byte_count, 32'd0);
    in_req = 1'b0;
    count_hold(n);
    check_eq("s2_hold_len", 32'(n), 32'd3);
    file_found = 1'b1; tick(); file_found = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick(); n++;
    end
    check_eq("s2_empty_latency", 32'(n), 32'd20);
    check_eq("s2_empty_cnt", byte_count, 32'd0);
    check_eq("s2_empty_done", 32'(done), 32'd1);

    // Session 3: file never found, three attempts then FAIL.
    start = 1'b1; tick(); start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      check_eq($sformatf("s3_retry_%0d", a), 32'(retry_cnt), 32'(a));
      count_hold(n);
      check_eq($sformatf("s3_hold_%0d", a), 32'(n), 32'd4);
      n = 0;
      while (reader_rst_n == 1'b1 && n < 500) begin
        n++; tick();
      end
      check_eq($sformatf("s3_search_%0d", a), 32'(n), 32'd100);
    end
    check_eq("s3_fail_flags", {29'd0, busy, done, fail}, 32'd1);
    check_eq("s3_fail_reader_rst_n", 32'(reader_rst_n), 32'd0);
    check_eq("s3_fail_retry", 32'(retry_cnt), 32'd2);

    // Session 4: five bytes, then asynchronous reset mid-stream.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("s4_restart", {27'd0, retry_cnt, busy, fail}, 32'd2);
    count_hold(n);
    in_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_byte = 8'(i); tick();
      check_eq($sformatf("s4_byte_%0d", i), {23'd0, out_req, out_byte}, 32'h100 + 32'(i));
    end
    check_eq("s4_cnt", byte_count, 32'd5);
    in_byte = 8'h06;
    #2 rst_n = 1'b0;
    #1;
    check_eq("s4_async_out", {7'd0, reader_rst_n, out_req, out_byte, retry_cnt, busy, done, fail, 9'd0}, 32'd0);
    check_eq("s4_async_cnt", byte_count, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("s4_post_rst_%0d", k), {30'd0, out_req, busy}, 32'd0);
    end
    in_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_read_supervisor.md
SD_READ_SUPERVISOR -- requirements
Module: sd_read_supervisor

Interface
REQ-001 Parameter RESTART_CYCLES, default 1000: cycles reader_rst_n is held low per restart (>=1).
REQ-002 Parameter FIND_TIMEOUT, default 100000000: max cycles in SEARCH before a retry (>=1).
REQ-003 Parameter IDLE_TIMEOUT, default 50000000: cycles without in_req in STREAM that end the file (>=1).
REQ-004 Parameter MAX_RETRY, default 3: restarts permitted after the first attempt (0..15).
REQ-005 Parameter AUTO_START, default 1: 1 = begin an attempt automatically after reset release.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle pulse, begin a new read session.
REQ-009 reader_rst_n  out  1  active-low reset driven to the sd_file_reader instance.
REQ-010 file_found  in  1  file_found from the reader.
REQ-011 in_req  in  1  reader outreq, one byte valid this cycle.
REQ-012 in_byte  in  8  reader outbyte.
REQ-013 out_req  out  1  forwarded byte strobe to consumer.
REQ-014 out_byte  out  8  forwarded byte.
REQ-015 byte_count  out  32  bytes forwarded this session.
REQ-016 retry_cnt  out  4  restarts performed this session.
REQ-017 busy / done / fail  out  1 each  session status flags.

Function
REQ-018 States: IDLE, HOLD, SEARCH, STREAM, DONE, FAIL; exactly one active.
REQ-019 IDLE: reader_rst_n=0; start (or first cycle after reset release when AUTO_START=1) -> HOLD, clear byte_count, retry_cnt, done, fail.
REQ-020 HOLD: reader_rst_n=0 for exactly RESTART_CYCLES cycles, then -> SEARCH with reader_rst_n=1 from the first SEARCH cycle.
REQ-021 SEARCH: timer counts from 0; file_found=1 or in_req=1 -> STREAM; timer reaching FIND_TIMEOUT with neither -> retry rule (REQ-024).
REQ-022 STREAM: every in_req produces out_req=1 and out_byte=in_byte on the next cycle (1-cycle registered latency, no drops, back-to-back in_req supported); byte_count increments by 1 in the same cycle as out_req.
REQ-023 STREAM: idle counter reset on each in_req; reaching IDLE_TIMEOUT consecutive cycles without in_req -> DONE, done=1; also applies with byte_count=0 (empty file).
REQ-024 Retry rule: if retry_cnt < MAX_RETRY -> retry_cnt+1, HOLD; else -> FAIL, fail=1.
REQ-025 in_req in SEARCH forwarded as in STREAM (same cycle as transition); in_req in IDLE, HOLD, DONE, FAIL dropped (out_req stays 0).
REQ-026 DONE/FAIL: reader_rst_n holds its value (1 in DONE, 0 in FAIL); start -> HOLD with REQ-019 clears.
REQ-027 start in HOLD, SEARCH or STREAM ignored.
REQ-028 busy=1 exactly in HOLD, SEARCH, STREAM; done and fail never both 1.
REQ-029 byte_count saturates at 32'hFFFFFFFF; retry_cnt never exceeds MAX_RETRY.
REQ-030 file_found falling during STREAM has no effect.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, reader_rst_n=0, out_req=0, out_byte=0, byte_count=0, retry_cnt=0, busy=0, done=0, fail=0, all timers 0, including mid-stream.
REQ-032 State leaves IDLE no earlier than the first clk edge after rst_n deasserts.

Verification (RESTART_CYCLES=4, FIND_TIMEOUT=100, IDLE_TIMEOUT=20, MAX_RETRY=2, AUTO_START=0)
REQ-033 start pulse, file_found=1 at SEARCH cycle 10, bytes 0x48,0x69 on consecutive cycles, then silence -> reader_rst_n low exactly 4 cycles; out_req on two consecutive cycles with 0x48,0x69; done=1 20 cycles after last in_req; byte_count=2.
REQ-034 start, file_found held 0 -> three attempts (retry_cnt 0,1,2), each with 4-cycle reader_rst_n low; after third 100-cycle timeout fail=1, busy=0, reader_rst_n=0.
REQ-035 file_found=1, no bytes -> done=1 after 20 idle cycles, byte_count=0.
REQ-036 rst_n pulsed low mid-stream after 5 bytes -> all outputs at REQ-031 values immediately; in_req thereafter produces no out_req until new start.
REQ-037 start pulsed during STREAM and in_req during HOLD -> no state change, no out_req; start in DONE -> byte_count=0, done=0, new HOLD phase.
